// File: rtl/out_pkg.sv
// Shared types and defaults for the OUT-port drain stage.
//   out_state_t : drain sequencer states
//   OUT_DEPTH   : default queue depth (power of two, >= 2)
//   OUT_W       : default data width
package out_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } out_state_t;

  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned OUT_W     = 16;

endpackage

// File: rtl/out_buffer_if.sv
// Valid/ready handshake toward the external display/serial sink.
//   out_valid : head entry is valid        (master -> slave)
//   out_data  : head entry                 (master -> slave)
//   out_ready : sink accepts the head      (slave  -> master)
interface out_buffer_if #(
  parameter int unsigned W = out_pkg::OUT_W
) ();

  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/out_fifo.sv
// Synchronous circular-buffer FIFO. Storage is not reset; only pointers and
// occupancy are.
//   clk, reset : clock, async active-high reset
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   full, empty, count : occupancy status
//   head       : entry at the read pointer
module out_fifo import out_pkg::*; #(
  parameter int unsigned DEPTH = OUT_DEPTH,
  parameter int unsigned W     = OUT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage, intentionally without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/out_buffer.sv
// OUT-instruction drain stage: queues committed OUT operands, drains them to
// the external sink, back-pressures the pipeline when full, and sequences HLT
// so halted is reported only after the queue has emptied.
//   clk, reset  : core clock, async active-high reset
//   out_en_ex   : OUT instruction in EX
//   out_dat_ex  : forwarded OUT operand
//   adv_ex      : EX instruction commits this cycle
//   is_halt_ex  : HLT instruction in EX
//   out_stall   : hold ID/EX and upstream stages
//   sink        : valid/ready port toward the display/serial sink
//   halted      : HLT committed and queue drained (sticky until reset)
//   count       : current queue occupancy
module out_buffer import out_pkg::*; #(
  parameter int unsigned DEPTH = OUT_DEPTH,
  parameter int unsigned W     = OUT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   out_en_ex,
  input  logic [W-1:0]           out_dat_ex,
  input  logic                   adv_ex,
  input  logic                   is_halt_ex,
  output logic                   out_stall,
  out_buffer_if.master           sink,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  out_state_t    state;
  out_state_t    state_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          valid;
  logic          halt_commit;
  logic          last_pop;
  logic [W-1:0]  head;
  logic [CW-1:0] fifo_count;

  out_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (out_dat_ex),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (head)
  );

  // A concurrent HLT wins over OUT; nothing is accepted once draining starts.
  assign halt_commit = is_halt_ex & adv_ex;
  assign push        = out_en_ex & adv_ex & ~full & ~is_halt_ex & (state == RUN);
  assign valid       = ~empty & (state != HALTED);
  assign pop         = valid & sink.out_ready;
  // Pushes are blocked whenever this matters, so a pop at 1 empties the queue.
  assign last_pop    = pop & (fifo_count == CW'(1));

  assign sink.out_valid = valid;
  assign sink.out_data  = valid ? head : '0;
  assign out_stall      = out_en_ex & full;
  assign halted         = (state == HALTED);
  assign count          = fifo_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Drain sequencer: halted follows the cycle in which the queue becomes empty.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (halt_commit) state_next = (empty | last_pop) ? HALTED : DRAIN;
      end
      DRAIN: begin
        if (empty | last_pop) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_out_buffer.sv
// Self-checking bench for out_buffer: directed vector tables, hand-written
// multi-cycle sequences, and randomized traffic checked against a queue model.
module tb_out_buffer;
  import out_pkg::*;

  localparam int unsigned DEPTH = OUT_DEPTH;
  localparam int unsigned W     = OUT_W;

  typedef struct {
    logic         en;
    logic [W-1:0] dat;
    logic         adv;
    logic         halt;
    logic         rdy;
    logic         e_valid;
    logic [W-1:0] e_data;
    int           e_count;
    logic         e_stall;
    logic         e_halted;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   out_en_ex;
  logic [W-1:0]           out_dat_ex;
  logic                   adv_ex;
  logic                   is_halt_ex;
  logic                   out_stall;
  logic                   halted;
  logic [$clog2(DEPTH):0] count;

  out_buffer_if #(.W(W)) bus ();

  out_buffer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .out_en_ex  (out_en_ex),
    .out_dat_ex (out_dat_ex),
    .adv_ex     (adv_ex),
    .is_halt_ex (is_halt_ex),
    .out_stall  (out_stall),
    .sink       (bus.master),
    .halted     (halted),
    .count      (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue contents plus "halt pending" / "halted" flags.
  logic [W-1:0] mq [$];
  bit           m_drain;
  bit           m_halted;

  function automatic vec_t mk(logic en, logic [W-1:0] dat, logic adv, logic halt, logic rdy,
                              logic ev, logic [W-1:0] ed, int ec, logic es, logic eh);
    vec_t v;
    v.en = en; v.dat = dat; v.adv = adv; v.halt = halt; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_stall = es; v.e_halted = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the pre-edge view.
  task automatic model_step(input vec_t v);
    bit pop, push;
    pop  = (mq.size() != 0) && !m_halted && v.rdy;
    push = v.en && v.adv && !v.halt && (mq.size() < DEPTH) && !m_drain && !m_halted;
    if (!m_drain && !m_halted && v.halt && v.adv) m_drain = 1'b1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(v.dat);
    if (m_drain && mq.size() == 0) begin
      m_halted = 1'b1;
      m_drain  = 1'b0;
    end
  endtask

  // Called at posedge+1: drive, check outputs mid-cycle, cross the edge.
  task automatic cycle(input vec_t v, input bit from_model, input string tag);
    logic         ev, es, eh;
    logic [W-1:0] ed;
    int           ec;
    out_en_ex     = v.en;
    out_dat_ex    = v.dat;
    adv_ex        = v.adv;
    is_halt_ex    = v.halt;
    bus.out_ready = v.rdy;
    #2;
    if (from_model) begin
      ev = (mq.size() != 0) && !m_halted;
      ed = ev ? mq[0] : '0;
      ec = mq.size();
      es = v.en && (mq.size() == DEPTH);
      eh = m_halted;
    end else begin
      ev = v.e_valid; ed = v.e_data; ec = v.e_count; es = v.e_stall; eh = v.e_halted;
    end
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, " out_data"},  32'(bus.out_data),  32'(ed));
    chk({tag, " count"},     32'(count),         32'(ec));
    chk({tag, " out_stall"}, 32'(out_stall),     32'(es));
    chk({tag, " halted"},    32'(halted),        32'(eh));
    @(posedge clk);
    #1;
    model_step(v);
  endtask

  // Assert reset away from the clock edge; outputs must clear immediately.
  task automatic do_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    chk({tag, " rst out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " rst out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, " rst count"},     32'(count),         32'd0);
    chk({tag, " rst halted"},    32'(halted),        32'd0);
    chk({tag, " rst out_stall"}, 32'(out_stall),     32'd0);
    mq.delete();
    m_drain  = 1'b0;
    m_halted = 1'b0;
    out_en_ex = 1'b0; out_dat_ex = '0; adv_ex = 1'b0; is_halt_ex = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [$];
    vec_t v;
    bit   stalled;
    int   rdy_pct;

    reset = 1'b1;
    out_en_ex = 1'b0; out_dat_ex = '0; adv_ex = 1'b0; is_halt_ex = 1'b0; bus.out_ready = 1'b0;
    m_drain = 1'b0; m_halted = 1'b0;
    #1;
    chk("init out_valid", 32'(bus.out_valid), 32'd0);
    chk("init count",     32'(count),         32'd0);
    chk("init halted",    32'(halted),        32'd0);
    chk("init out_data",  32'(bus.out_data),  32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    //          en dat      adv hlt rdy  valid data    cnt stall halted
    // Streaming with the sink always ready.
    tbl.push_back(mk(1, 16'h0001, 1, 0, 1, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0002, 1, 0, 1, 1, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(1, 16'h0003, 1, 0, 1, 1, 16'h0002, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 1, 16'h0003, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 0, 0));
    // Fill to full with sink blocked, 5th OUT stalls in EX.
    tbl.push_back(mk(1, 16'h0001, 1, 0, 0, 0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0002, 1, 0, 0, 1, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(1, 16'h0003, 1, 0, 0, 1, 16'h0001, 2, 0, 0));
    tbl.push_back(mk(1, 16'h0004, 1, 0, 0, 1, 16'h0001, 3, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 0, 1, 16'h0001, 4, 1, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 1, 1, 16'h0001, 4, 1, 0));
    tbl.push_back(mk(1, 16'h0005, 1, 0, 0, 1, 16'h0002, 3, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 1, 16'h0002, 4, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 1, 16'h0003, 3, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 1, 16'h0004, 2, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 1, 16'h0005, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 0, 0));
    foreach (tbl[i]) cycle(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Steady-state push/pop at occupancy 1 across several pointer wraps.
    cycle(mk(1, 16'h0100, 1, 0, 1, 0, 16'h0000, 0, 0, 0), 1'b0, "wrap_fill");
    for (int i = 0; i < 10; i++)
      cycle(mk(1, 16'(16'h0101 + i), 1, 0, 1, 1, 16'(16'h0100 + i), 1, 0, 0), 1'b0,
            $sformatf("wrap%0d", i));
    cycle(mk(0, 16'h0000, 1, 0, 1, 1, 16'h010A, 1, 0, 0), 1'b0, "wrap_last");
    cycle(mk(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0), 1'b0, "wrap_empty");

    // HLT with two entries queued and the sink blocked, then released.
    cycle(mk(1, 16'h00A1, 1, 0, 0, 0, 16'h0000, 0, 0, 0), 1'b0, "hlt2_p1");
    cycle(mk(1, 16'h00A2, 1, 0, 0, 1, 16'h00A1, 1, 0, 0), 1'b0, "hlt2_p2");
    cycle(mk(0, 16'h0000, 1, 1, 0, 1, 16'h00A1, 2, 0, 0), 1'b0, "hlt2_commit");
    cycle(mk(1, 16'hDEAD, 1, 0, 0, 1, 16'h00A1, 2, 0, 0), 1'b0, "hlt2_drain_ign");
    cycle(mk(1, 16'hBEEF, 1, 0, 1, 1, 16'h00A1, 2, 0, 0), 1'b0, "hlt2_pop1");
    cycle(mk(0, 16'h0000, 1, 0, 1, 1, 16'h00A2, 1, 0, 0), 1'b0, "hlt2_pop2");
    cycle(mk(1, 16'hCAFE, 1, 0, 1, 0, 16'h0000, 0, 0, 1), 1'b0, "hlt2_halted");
    cycle(mk(1, 16'hCAFE, 1, 0, 1, 0, 16'h0000, 0, 0, 1), 1'b0, "hlt2_sticky");

    // HLT with an empty queue.
    do_reset("hlt0");
    cycle(mk(0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0, 0, 0), 1'b0, "hlt0_commit");
    cycle(mk(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 0, 1), 1'b0, "hlt0_halted");
    cycle(mk(1, 16'h0005, 1, 0, 1, 0, 16'h0000, 0, 0, 1), 1'b0, "hlt0_ign");

    // Reset while draining three entries, then resume.
    do_reset("mid");
    cycle(mk(1, 16'h00C1, 1, 0, 0, 0, 16'h0000, 0, 0, 0), 1'b0, "mid_p1");
    cycle(mk(1, 16'h00C2, 1, 0, 0, 1, 16'h00C1, 1, 0, 0), 1'b0, "mid_p2");
    cycle(mk(1, 16'h00C3, 1, 0, 0, 1, 16'h00C1, 2, 0, 0), 1'b0, "mid_p3");
    cycle(mk(0, 16'h0000, 1, 1, 0, 1, 16'h00C1, 3, 0, 0), 1'b0, "mid_commit");
    is_halt_ex    = 1'b0;
    bus.out_ready = 1'b1;
    do_reset("mid_drain");
    cycle(mk(1, 16'h00E1, 1, 0, 1, 0, 16'h0000, 0, 0, 0), 1'b0, "resume_p");
    cycle(mk(0, 16'h0000, 1, 0, 1, 1, 16'h00E1, 1, 0, 0), 1'b0, "resume_v");
    cycle(mk(0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 0, 0), 1'b0, "resume_e");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      if (i % 61 == 60) do_reset($sformatf("rnd_rst%0d", i));
      rdy_pct = ((i / 150) % 2 == 0) ? 80 : 25;
      v.en    = ($urandom_range(0, 1) == 1);
      v.dat   = W'($urandom);
      stalled = v.en && (mq.size() == DEPTH);
      v.adv   = stalled ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
      v.halt  = ($urandom_range(0, 79) == 0);
      v.rdy   = ($urandom_range(0, 99) < rdy_pct);
      v.e_valid = 1'b0; v.e_data = '0; v.e_count = 0; v.e_stall = 1'b0; v.e_halted = 1'b0;
      cycle(v, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_buffer.md
# out_buffer

Output-port drain stage for the 16-bit pipelined core. It sits directly downstream of the ID/EX pipeline register and consumes its `out_en_ex` / `is_halt_ex` controls plus the forwarded EX-stage operand. It queues OUT-instruction data in a small FIFO, drains it to the external display/serial port over a valid/ready handshake, and back-pressures the pipeline when the queue is full. It also sequences HLT so that the core reports halted only after every queued output has left the chip.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `W`, 16: data width.

Ports:
- `clk`, in, 1: core clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `out_en_ex`, in, 1: the instruction in EX is OUT.
- `out_dat_ex`, in, W: forwarded OUT operand (post-forwarding-mux rd1).
- `adv_ex`, in, 1: EX stage advances this cycle, i.e. the instruction commits to EX/MEM.
- `is_halt_ex`, in, 1: the instruction in EX is HLT.
- `out_stall`, out, 1: hold ID/EX and the upstream stages; the top level folds this into `en_idex` and the IF/ID enable.
- `out_valid`, out, 1: `out_data` is valid.
- `out_data`, out, W: FIFO head.
- `out_ready`, in, 1: the external sink accepts the head.
- `halted`, out, 1: HLT has committed and the FIFO is empty. Sticky.
- `count`, out, $clog2(DEPTH)+1: current occupancy.

## Operation

Terms:
- push = `out_en_ex & adv_ex & ~full & (state==RUN)`
- pop = `out_valid & out_ready`

Stall:
- `out_stall = out_en_ex & full`. Purely combinational from registered `full`.
- There is no same-cycle pop bypass. A pop frees a slot, and the stall drops on the next cycle.

FIFO:
- Circular buffer with wr_ptr / rd_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- `count` is tracked separately: push-only gives +1, pop-only gives −1, push&pop gives unchanged.
- `full = (count==DEPTH)`, `empty = (count==0)`.
- Simultaneous push and pop is legal at any non-full occupancy.
- On push and pop at count 1, the new entry becomes the head next cycle with no bubble.
- A push while full cannot occur because `adv_ex` is low under stall. If the top level drives it anyway, the push is dropped and the FIFO is unchanged.

State machine, with states RUN, DRAIN and HALTED:
- RUN to DRAIN: on `is_halt_ex & adv_ex` when the FIFO is non-empty, or when a pop is not emptying it.
- RUN to HALTED: on `is_halt_ex & adv_ex` when the FIFO is empty, or becomes empty that cycle.
- DRAIN: pushes are ignored and pops continue. Go to HALTED on the cycle after count reaches 0.
- HALTED: terminal until reset. `halted` = 1 and `out_valid` = 0.
- Simultaneous `out_en_ex` and `is_halt_ex` is impossible, since a single instruction occupies EX. If both are asserted, the halt wins and the push is ignored.

## Timing

- Reset values (async assert, sync-to-clk deassert handled at the top level):
  - state = RUN
  - pointers = 0, `count` = 0
  - `out_valid` = 0, `out_data` = 0
  - `halted` = 0, `out_stall` = 0
- Latency from a push to `out_valid` for that entry: 1 cycle. `out_data` and `out_valid` are registered or derived from registered state only.
- Once asserted, `out_valid` holds and `out_data` stays stable until pop.
- `halted` rises 1 cycle after the final pop, or 1 cycle after the HLT commit if the FIFO is already empty.
- If reset asserts mid-drain, all queued data is discarded, with no partial handshake completion.
- FIFO storage is not reset. Only the control state is reset.

## Structure

- Package `out_pkg`:
  - `typedef enum logic [1:0] {RUN, DRAIN, HALTED} out_state_t`
  - `localparam OUT_DEPTH = 4`
  - `localparam OUT_W = 16`
- Sub-module `out_fifo` is a synchronous FIFO with push, pop, full, empty, count and head.
- `out_buffer` wraps `out_fifo` with the stall logic and the FSM.
- Total size is about 180 lines.

## Test plan

1. After reset, drive 3 OUT commits (0x0001, 0x0002, 0x0003) with `out_ready`=1. Expect `out_data` to show 0x0001, 0x0002, 0x0003 on consecutive cycles, starting 1 cycle after the first push, with `out_stall` never asserted.
2. With `out_ready`=0, issue 5 OUT commits. After 4 pushes, expect `count`=4 and `out_stall`=1 while the 5th is in EX. Raise `out_ready` for 1 cycle. Expect `out_stall` to drop the next cycle, the 5th to push, and FIFO order 0x0002..0x0005 to be preserved.
3. Wrap-around: run 10 push/pop pairs at steady state with count held at 1. Expect data integrity across pointer wrap and `count` constant at 1.
4. HLT with 2 entries queued and `out_ready`=0: expect `halted`=0 with state DRAIN. Release `out_ready`: expect 2 pops, then `halted`=1 one cycle after the last pop. Any further `out_en_ex` is ignored.
5. HLT with an empty FIFO: expect `halted`=1 on the cycle after the commit.
6. Assert `reset` mid-drain with 3 entries queued: expect `out_valid`, `count` and `halted` to clear immediately (asynchronously), and normal operation to resume after reset.
